comparator_4bit: RTL and testbench

//   Cascadable unsigned magnitude comparator, 74x85 style, with registered outputs.
//   - Compares operand a against operand b.
//   - When a == b, the result is taken from the cascade inputs, which come from a

---
 rtl/comparator_4bit_if.sv | 39 +++
 rtl/comparator_4bit.sv | 63 ++++++
 tb/tb_comparator_4bit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/comparator_4bit_if.sv
// Operand, cascade and result bundle for one cascadable magnitude-comparator stage.
// The master drives operands and cascade inputs; the slave is the comparator stage itself.
interface comparator_4bit_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             i_a_gt_b;
    logic             i_a_eq_b;
    logic             i_a_lt_b;
    logic             o_a_gt_b;
    logic             o_a_eq_b;
    logic             o_a_lt_b;
    logic             o_cas_err;

    modport master (
        output a,
        output b,
        output i_a_gt_b,
        output i_a_eq_b,
        output i_a_lt_b,
        input  o_a_gt_b,
        input  o_a_eq_b,
        input  o_a_lt_b,
        input  o_cas_err
    );

    modport slave (
        input  a,
        input  b,
        input  i_a_gt_b,
        input  i_a_eq_b,
        input  i_a_lt_b,
        output o_a_gt_b,
        output o_a_eq_b,
        output o_a_lt_b,
        output o_cas_err
    );
endinterface

// File: rtl/comparator_4bit.sv
// Cascadable unsigned magnitude comparator (74x85 style) with registered, one-hot results.
// Operand equality defers to the cascade inputs from the lower-significance stage.
module comparator_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    comparator_4bit_if.slave   bus
);

    logic mag_gt;
    logic mag_lt;
    logic gt_d, eq_d, lt_d, err_d;
    logic gt_q, eq_q, lt_q, err_q;

    // Unsigned relational compare is the MSB-first magnitude decision.
    always_comb begin
        mag_gt = (bus.a > bus.b);
        mag_lt = (bus.a < bus.b);
    end

    always_comb begin
        gt_d  = 1'b0;
        eq_d  = 1'b0;
        lt_d  = 1'b0;
        err_d = 1'b0;
        if (mag_gt) begin
            gt_d = 1'b1;
        end else if (mag_lt) begin
            lt_d = 1'b1;
        end else if (bus.i_a_eq_b) begin
            eq_d = 1'b1;
        end else if (bus.i_a_gt_b && !bus.i_a_lt_b) begin
            gt_d = 1'b1;
        end else if (bus.i_a_lt_b && !bus.i_a_gt_b) begin
            lt_d = 1'b1;
        end else begin
            // Illegal cascade code: report equal so the result stays one-hot.
            eq_d  = 1'b1;
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gt_q  <= 1'b0;
            eq_q  <= 1'b1;
            lt_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            gt_q  <= gt_d;
            eq_q  <= eq_d;
            lt_q  <= lt_d;
            err_q <= err_d;
        end
    end

    assign bus.o_a_gt_b  = gt_q;
    assign bus.o_a_eq_b  = eq_q;
    assign bus.o_a_lt_b  = lt_q;
    assign bus.o_cas_err = err_q;

endmodule

// File: tb/tb_comparator_4bit.sv
// Directed-table, exhaustive and reset-sequence bench for the cascadable comparator.
module tb_comparator_4bit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    comparator_4bit_if #(.WIDTH(4)) bus ();

    comparator_4bit #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] cas;  // {gt, eq, lt}
        logic [3:0] exp;  // {gt, eq, lt, cas_err}
    } vec_t;

    vec_t vecs[13];

    function automatic logic [3:0] outs();
        return {bus.o_a_gt_b, bus.o_a_eq_b, bus.o_a_lt_b, bus.o_cas_err};
    endfunction

    // Reference: integer compare first, then cascade priority eq > gt-only > lt-only > error.
    function automatic logic [3:0] model(input int ai, input int bi, input logic [2:0] cas);
        if (ai > bi) return 4'b1000;
        if (ai < bi) return 4'b0010;
        if (cas[1]) return 4'b0100;
        if (cas[2] && !cas[0]) return 4'b1000;
        if (cas[0] && !cas[2]) return 4'b0010;
        return 4'b0101;
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got gt/eq/lt/err=%b required %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] cas);
        bus.a        = a;
        bus.b        = b;
        bus.i_a_gt_b = cas[2];
        bus.i_a_eq_b = cas[1];
        bus.i_a_lt_b = cas[0];
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [2:0] cas);
        @(negedge clk);
        drive(a, b, cas);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] prev_exp;
    logic [3:0] o;
    bit         have_prev;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{"eq_zero_caseq",   4'h0, 4'h0, 3'b010, 4'b0100};
        vecs[1]  = '{"eq_zero_casgt",   4'h0, 4'h0, 3'b100, 4'b1000};
        vecs[2]  = '{"eq_zero_caslt",   4'h0, 4'h0, 3'b001, 4'b0010};
        vecs[3]  = '{"a5_b0_gt",        4'h5, 4'h0, 3'b010, 4'b1000};
        vecs[4]  = '{"a5_b8_lt",        4'h5, 4'h8, 3'b010, 4'b0010};
        vecs[5]  = '{"max_max_eq",      4'hF, 4'hF, 3'b010, 4'b0100};
        vecs[6]  = '{"eq_cas000_err",   4'h3, 4'h3, 3'b000, 4'b0101};
        vecs[7]  = '{"eq_cas101_err",   4'h3, 4'h3, 3'b101, 4'b0101};
        vecs[8]  = '{"gt_cas000_noerr", 4'h4, 4'h3, 3'b000, 4'b1000};
        vecs[9]  = '{"zero_vs_max",     4'h0, 4'hF, 3'b010, 4'b0010};
        vecs[10] = '{"max_vs_zero",     4'hF, 4'h0, 3'b010, 4'b1000};
        vecs[11] = '{"eq_cas111_eq",    4'h3, 4'h3, 3'b111, 4'b0100};
        vecs[12] = '{"lt_cas101_noerr", 4'h2, 4'h9, 3'b101, 4'b0010};

        // Reset with arbitrary inputs present.
        rst = 1'b1;
        drive(4'h5, 4'h0, 3'b101);
        @(posedge clk);
        #1;
        check("reset", outs(), 4'b0100);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].cas);
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // Exhaustive, pipelined: at each falling edge the outputs must reflect the
        // stimulus applied exactly one cycle earlier.
        have_prev = 1'b0;
        for (int v = 0; v < 2048; v++) begin
            logic [3:0] ea;
            logic [3:0] eb;
            logic [2:0] ec;
            @(negedge clk);
            if (have_prev) begin
                o = outs();
                check("exhaustive", o, prev_exp);
                check("onehot", {3'b000, ($countones(o[3:1]) == 1)}, 4'b0001);
            end
            ea = v[10:7];
            eb = v[6:3];
            ec = v[2:0];
            drive(ea, eb, ec);
            prev_exp  = model(int'(ea), int'(eb), ec);
            have_prev = 1'b1;
        end
        @(negedge clk);
        check("exhaustive_last", outs(), prev_exp);

        // Reset mid-stream while a > b, then recovery.
        step(4'h9, 4'h2, 3'b010);
        check("pre_rst_gt", outs(), 4'b1000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst", outs(), 4'b0100);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_gt", outs(), 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
